gen_inf_arb: RTL and testbench
==============================

# gen_inf_arb

Two-requester arbiter and sequencer in front of the `gen_inf` register interface. It shares the single-port register bus (`we`/`addr`/`wdata`/`rdata`) and the `start`/`ready` handshake between two requesters using round-robin arbitration. It issues registered bus cycles, captures read data and returns it per requester. For start operations it pulses `start` and waits for `ready`, bounded by a timeout.

## Interface
- `DEPTH`, 5, address width; must match the sequenced `gen_inf` instance.
- `TIMEOUT`, 1024, maximum RUN cycles to wait for `m_ready` (≥2).
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqN` in 1 (N=0,1): register access request; level held until `gntN` is sampled.
- `kickN` in 1: start request; level held until `gntN` is sampled.
- `weN` in 1: 1 = write, 0 = read; qualifies `reqN`.
- `addrN` in DEPTH: access address.
- `wdataN` in 32: write data.
- `gntN` out 1: one-cycle acceptance pulse.
- `rvalidN` out 1: one-cycle read-data-valid pulse.
- `rdataN` out 32: read data; holds its value until the next read for N.
- `doneN` out 1: one-cycle start-operation-complete pulse.
- `errN` out 1: equals 1 with `doneN` when the operation timed out; 0 otherwise.
- `m_we` out 1, `m_addr` out DEPTH, `m_wdata` out 32: to `gen_inf` `we`/`addr`/`wdata`.
- `m_rdata` in 32: from `gen_inf` `rdata`; valid one cycle after `m_addr` is presented.
- `m_start` out 1, `m_ready` in 1: to/from `gen_inf` `start`/`ready`.

## Operation
- FSM states: IDLE, ACC, CAP, START, RUN. All outputs are registered.
- Reset (async): state IDLE; all outputs 0, including `m_addr`, `m_wdata` and `rdataN`; round-robin pointer favours requester 0.
- **Candidate selection (IDLE only).** Requester N is a candidate if `reqN|kickN`.
  - Within a requester, `kickN` takes priority over `reqN`.
  - Between requesters: if both are candidates, the one not granted last wins; otherwise the sole candidate wins.
  - The pointer updates on every grant.
- **IDLE, winner is a req.**
  - Load `m_addr`/`m_wdata` from the winner, set `m_we`=`weN`, set `gntN`=1.
  - Next state ACC.
  - Remember the winner and the read/write type.
- **ACC.**
  - `m_we` drops to 0 at the end of ACC.
  - Read: go to CAP. Write: go to IDLE.
- **CAP.** `rdataN`←`m_rdata`, `rvalidN`←1, go to IDLE.
- **IDLE, winner is a kick.**
  - Set `m_start`=1 and `gntN`=1.
  - Next state START.
- **START.** `m_start`←0, clear the timeout counter, go to RUN.
- **RUN.** Priority order each cycle:
  - `m_ready`=1: `doneN`←1, go to IDLE.
  - Else counter == TIMEOUT-1: `doneN`←1, `errN`←1, go to IDLE.
  - Else increment the counter.
  - `m_ready` is ignored before the first RUN cycle.
- `m_addr`/`m_wdata` hold their last values outside ACC.
- No new grant is issued while the FSM is outside IDLE.
- Requests arriving while busy wait; they are not lost.
- Requester contract: deassert `reqN`/`kickN` on the edge that samples `gntN`=1; keep `weN`/`addrN`/`wdataN` stable while `reqN` is high.
- Reset asserted mid-operation aborts the operation. No further `gnt`/`rvalid`/`done` pulses are issued for it, and `m_we`/`m_start` clear immediately.

## Timing
- **Read**, `req` seen in IDLE in cycle T:
  - `gnt` and bus drive in T+1.
  - `m_rdata` valid in T+2.
  - `rvalid`/`rdata` in T+3.
  - FSM back in IDLE in T+3 and may grant in T+3.
- **Write:**
  - `gnt`, `m_we`=1 and bus drive in T+1.
  - IDLE again in T+2.
- **Kick:**
  - `gnt` and `m_start` in T+1.
  - First RUN cycle T+2.
  - `done` is at earliest T+3 (`m_ready` high in T+2).
- Timeout: `done`+`err` occur TIMEOUT cycles after the first RUN cycle when `m_ready` never rises.
- Throughput: one read per 3 cycles, one write per 2 cycles.
- `gntN`, `rvalidN`, `doneN`, `m_start` and `m_we` are never high for more than one consecutive cycle per operation.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle → all outputs 0 immediately. After release with no requests, the bus stays idle.
- **Write then read.** req0 writes 0xDEADBEEF to addr 3; then req0 reads addr 3 →
  - `m_we`=1 for exactly 1 cycle;
  - `rvalid0` 3 cycles after the read req is seen;
  - `rdata0`=0xDEADBEEF.
- **Contention.** req0 and req1 both read (addr 1 and addr 2) in the same cycle →
  - `gnt0` first, then `gnt1` 3 cycles later;
  - each `rdataN` matches its own address.
  - Repeat with both requesters continuously requesting → grants strictly alternate.
- **Kick.**
  - kick1 with `m_ready` rising 5 cycles after `m_start` → `m_start` 1-cycle pulse; `done1`=1, `err1`=0 one cycle after `m_ready` is seen.
  - kick0 and req0 together → kick served first.
- **Timeout.** TIMEOUT=8 and `m_ready` held 0 → `done0`=`err0`=1 exactly 8 cycles after the first RUN cycle; the next request is then served normally.
- **Reset mid-operation.** Assert `rst` during RUN and, separately, during CAP → no `done`/`rvalid` pulse; the FSM is in IDLE after release.

Source files
------------

// File: rtl/gen_inf_arb.sv
// Two-requester round-robin arbiter/sequencer in front of the gen_inf register interface.
// Issues registered bus cycles, returns read data per requester and supervises start/ready.
module gen_inf_arb #(
    parameter int unsigned DEPTH   = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             req0,
    input  logic             kick0,
    input  logic             we0,
    input  logic [DEPTH-1:0] addr0,
    input  logic [31:0]      wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [31:0]      rdata0,
    output logic             done0,
    output logic             err0,
    input  logic             req1,
    input  logic             kick1,
    input  logic             we1,
    input  logic [DEPTH-1:0] addr1,
    input  logic [31:0]      wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [31:0]      rdata1,
    output logic             done1,
    output logic             err1,
    output logic             m_we,
    output logic [DEPTH-1:0] m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             m_start,
    input  logic             m_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StAcc, StCap, StStart, StRun} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;   // requester granted most recently
    logic             cur_q, cur_d;     // requester owning the current operation
    logic             rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;
    logic             m_we_q, m_we_d;
    logic             m_start_q, m_start_d;
    logic [DEPTH-1:0] m_addr_q, m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;

    logic [1:0]       cand;
    logic             win;
    logic             win_kick;
    logic             win_we;
    logic [DEPTH-1:0] win_addr;
    logic [31:0]      win_wdata;

    always_comb begin
        cand      = {req1 | kick1, req0 | kick0};
        // On contention the requester not granted last wins.
        win       = (cand == 2'b11) ? ~last_q : cand[1];
        win_kick  = win ? kick1 : kick0;
        win_we    = win ? we1 : we0;
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cur_d     = cur_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        gnt_d     = 2'b00;
        rvalid_d  = 2'b00;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        m_we_d    = 1'b0;
        m_start_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (cand != 2'b00) begin
                    gnt_d[win] = 1'b1;
                    last_d     = win;
                    cur_d      = win;
                    if (win_kick) begin
                        m_start_d = 1'b1;
                        state_d   = StStart;
                    end else begin
                        m_we_d    = win_we;
                        m_addr_d  = win_addr;
                        m_wdata_d = win_wdata;
                        rd_d      = ~win_we;
                        state_d   = StAcc;
                    end
                end
            end
            StAcc: begin
                state_d = rd_q ? StCap : StIdle;
            end
            StCap: begin
                rvalid_d[cur_q] = 1'b1;
                if (cur_q) begin
                    rdata1_d = m_rdata;
                end else begin
                    rdata0_d = m_rdata;
                end
                state_d = StIdle;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                if (m_ready) begin
                    done_d[cur_q] = 1'b1;
                    state_d       = StIdle;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d[cur_q] = 1'b1;
                    err_d[cur_q]  = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            cur_q     <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            m_we_q    <= 1'b0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            m_we_q    <= m_we_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign m_we    = m_we_q;
    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_gen_inf_arb.sv
// Directed bench for gen_inf_arb: register-file model on the bus, scoreboard queues for
// read data and start-operation results, and latency/pulse checks at each step.
module tb_gen_inf_arb;

    localparam int unsigned DEPTH   = 5;
    localparam int unsigned TIMEOUT = 8;

    logic             clk_i = 1'b0;
    logic             rst;
    logic             req0, kick0, we0, req1, kick1, we1;
    logic [DEPTH-1:0] addr0, addr1;
    logic [31:0]      wdata0, wdata1;
    logic             gnt0, rvalid0, done0, err0, gnt1, rvalid1, done1, err1;
    logic [31:0]      rdata0, rdata1;
    logic             m_we, m_start, m_ready;
    logic [DEPTH-1:0] m_addr;
    logic [31:0]      m_wdata, m_rdata;

    gen_inf_arb #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst(rst),
        .req0(req0), .kick0(kick0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .done0(done0), .err0(err0),
        .req1(req1), .kick1(kick1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .done1(done1), .err1(err1),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_start(m_start), .m_ready(m_ready)
    );

    always #5 clk_i = ~clk_i;

    // Register file behind the bus: registered read, one cycle after the address.
    logic [31:0] mem [32];
    always @(posedge clk_i) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] exp_r0[$], exp_r1[$];
    logic        exp_d0[$], exp_d1[$];

    logic any_out;
    assign any_out = |{gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, done0, done1, err0, err1,
                       m_we, m_addr, m_wdata, m_start};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop on every result pulse; also every pulse must be single-cycle.
    logic [7:0] pv = '0;
    always @(negedge clk_i) begin
        logic [7:0] cv;
        if (rst) begin
            pv = '0;
        end else begin
            cv = {m_we, m_start, done1, done0, rvalid1, rvalid0, gnt1, gnt0};
            for (int i = 0; i < 8; i++) if (cv[i]) chk($sformatf("pulse_width_%0d", i), pv[i], 0);
            pv = cv;
            if (rvalid0) begin
                if (exp_r0.size() == 0) chk("unexpected_rvalid0", rvalid0, 0);
                else chk("sb_rdata0", rdata0, exp_r0.pop_front());
            end
            if (rvalid1) begin
                if (exp_r1.size() == 0) chk("unexpected_rvalid1", rvalid1, 0);
                else chk("sb_rdata1", rdata1, exp_r1.pop_front());
            end
            if (done0) begin
                if (exp_d0.size() == 0) chk("unexpected_done0", done0, 0);
                else chk("sb_err0", err0, exp_d0.pop_front());
            end
            if (done1) begin
                if (exp_d1.size() == 0) chk("unexpected_done1", done1, 0);
                else chk("sb_err1", err1, exp_d1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic sigv(int id);
        case (id)
            0: return gnt0;
            1: return gnt1;
            2: return rvalid0;
            3: return rvalid1;
            4: return done0;
            default: return done1;
        endcase
    endfunction

    task automatic wait_for(input int id, input int budget, output int at);
        int k = 0;
        while (!sigv(id) && k < budget) begin
            tick();
            k++;
        end
        at = sigv(id) ? cyc : -1;
    endtask

    // Raise a request; reads push expected data, writes update the reference memory.
    task automatic raise(input int n, input logic kick, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic push);
        if (kick) begin
            if (n == 0) kick0 = 1'b1; else kick1 = 1'b1;
        end else begin
            if (n == 0) begin
                req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
            end else begin
                req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
            end
            if (we) ref_mem[a] = d;
            else if (push) begin
                if (n == 0) exp_r0.push_back(ref_mem[a]); else exp_r1.push_back(ref_mem[a]);
            end
        end
    endtask

    task automatic push_done(input int n, input logic e);
        if (n == 0) exp_d0.push_back(e); else exp_d1.push_back(e);
    endtask

    // Wait for gntN and withdraw the request it served (kick has priority over req).
    task automatic wait_gnt(input int n, input int budget, output int at);
        wait_for(n, budget, at);
        if (at >= 0) begin
            if (n == 0) begin
                if (kick0) kick0 = 1'b0; else req0 = 1'b0;
            end else begin
                if (kick1) kick1 = 1'b0; else req1 = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, g, g2, r, d, rem0, rem1, k;
        logic exp_next;
        rst = 1'b1; m_ready = 1'b0;
        req0 = 0; kick0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; kick1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        tick(); tick();
        chk("reset_outputs", any_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_bus", {m_we, m_start, gnt0, gnt1}, 0);
        end

        // Write then read on requester 0.
        raise(0, 0, 1, 5'd3, 32'hDEADBEEF, 0); t0 = cyc;
        wait_gnt(0, 10, g);
        chk("wr_gnt_lat", g - t0, 1);
        chk("wr_m_we", m_we, 1);
        chk("wr_m_addr", m_addr, 3);
        chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
        tick();
        chk("wr_m_we_drop", m_we, 0);
        raise(0, 0, 0, 5'd3, 0, 1); t0 = cyc;
        wait_gnt(0, 10, g);
        wait_for(2, 10, r);
        chk("rd_rvalid_lat", r - t0, 3);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        tick(); tick();
        chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

        // Seed addresses 1 and 2 from both requesters.
        raise(1, 0, 1, 5'd1, 32'h1111_0001, 0); wait_gnt(1, 10, g); tick();
        raise(0, 0, 1, 5'd2, 32'h2222_0002, 0); wait_gnt(0, 10, g); tick();
        tick();

        // Asynchronous reset mid-cycle clears outputs (including held rdata0) at once.
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", any_out, 0);
        tick();
        rst = 1'b0;
        tick();

        // Contention right after reset: requester 0 first, requester 1 three cycles later.
        raise(0, 0, 0, 5'd1, 0, 1);
        raise(1, 0, 0, 5'd2, 0, 1); t0 = cyc;
        wait_gnt(0, 10, g);
        chk("cont_gnt0_lat", g - t0, 1);
        chk("cont_gnt1_low", gnt1, 0);
        wait_gnt(1, 10, g2);
        chk("cont_gnt1_gap", g2 - g, 3);
        wait_for(3, 10, r);
        chk("cont_rvalid1_lat", r - g2, 2);

        // Continuous requests from both: grants alternate, starting with requester 0.
        rem0 = 4; rem1 = 4; exp_next = 1'b0; k = 0;
        raise(0, 0, 0, 5'd1, 0, 1);
        raise(1, 0, 0, 5'd2, 0, 1);
        while ((rem0 + rem1) > 0 && k < 80) begin
            tick(); k++;
            if (gnt0 | gnt1) begin
                chk("alt_order", {gnt1, gnt0}, exp_next ? 2'b10 : 2'b01);
                if (gnt0) begin
                    rem0--;
                    if (rem0 > 0) exp_r0.push_back(ref_mem[1]); else req0 = 1'b0;
                end
                if (gnt1) begin
                    rem1--;
                    if (rem1 > 0) exp_r1.push_back(ref_mem[2]); else req1 = 1'b0;
                end
                exp_next = ~exp_next;
            end
        end
        if (k >= 80) chk("alt_budget", rem0 + rem1, 0);
        req0 = 0; req1 = 0;
        repeat (5) tick();

        // kick1 with m_ready rising five cycles after m_start.
        raise(1, 1, 0, 0, 0, 0); push_done(1, 0); t0 = cyc;
        wait_gnt(1, 10, g);
        chk("kick1_gnt_lat", g - t0, 1);
        chk("kick1_m_start", m_start, 1);
        tick();
        chk("kick1_m_start_drop", m_start, 0);
        repeat (4) tick();
        m_ready = 1'b1;
        wait_for(5, 10, d);
        chk("kick1_done_lat", d - g, 6);
        chk("kick1_err", err1, 0);
        m_ready = 1'b0;
        tick();

        // kick0 and req0 together: start operation first, then the read.
        m_ready = 1'b1;
        raise(0, 1, 0, 0, 0, 0); push_done(0, 0);
        raise(0, 0, 0, 5'd3, 0, 1); t0 = cyc;
        wait_gnt(0, 10, g);
        chk("kr_first_lat", g - t0, 1);
        chk("kr_first_is_kick", m_start, 1);
        chk("kr_first_no_we", m_we, 0);
        tick();
        wait_gnt(0, 10, g2);
        chk("kr_second_lat", g2 - t0, 4);
        chk("kr_second_no_start", m_start, 0);
        wait_for(2, 10, r);
        chk("kr_rvalid_lat", r - g2, 2);
        m_ready = 1'b0;
        tick();

        // Timeout: done0+err0 TIMEOUT cycles after the first RUN cycle.
        raise(0, 1, 0, 0, 0, 0); push_done(0, 1);
        wait_gnt(0, 10, g);
        wait_for(4, 30, d);
        chk("to_done_lat", d - (g + 1), TIMEOUT);
        chk("to_err0", err0, 1);
        tick();
        raise(0, 0, 0, 5'd1, 0, 1); t0 = cyc;
        wait_gnt(0, 10, g);
        chk("post_to_gnt_lat", g - t0, 1);
        wait_for(2, 10, r);
        chk("post_to_rvalid_lat", r - t0, 3);
        tick();

        // Reset during RUN: no done afterwards, FSM idle again.
        raise(1, 1, 0, 0, 0, 0);
        wait_gnt(1, 10, g);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1 chk("rst_run_outputs", any_out, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_run_no_done", done1, 0);
        end
        raise(0, 0, 0, 5'd3, 0, 1); t0 = cyc;
        wait_gnt(0, 10, g);
        wait_for(2, 10, r);
        chk("rst_run_idle_read", r - t0, 3);
        tick();

        // Reset during CAP: no rvalid afterwards, rdata1 cleared.
        raise(1, 0, 0, 5'd2, 0, 0);
        wait_gnt(1, 10, g);
        tick();
        #2 rst = 1'b1;
        #1 chk("rst_cap_outputs", any_out, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_cap_no_rvalid", rvalid1, 0);
        end
        chk("rst_cap_rdata1", rdata1, 0);
        raise(1, 0, 0, 5'd2, 0, 1); t0 = cyc;
        wait_gnt(1, 10, g);
        wait_for(3, 10, r);
        chk("rst_cap_idle_read", r - t0, 3);
        repeat (3) tick();

        chk("sb_leftover", exp_r0.size() + exp_r1.size() + exp_d0.size() + exp_d1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
